// File: rtl/bus_multi_dispatch.sv
// bus_multi_dispatch: routes one upstream wishbone master to NUM_SLAVES slaves by address field.
// Define BUS_MULTI_DISPATCH_TIMEOUT_EN to build the slave-ack timeout counter.
//
// state | meaning
// IDLE  | waiting for an upstream request
// FWD   | selected slave strobed, waiting for its ack, a cyc drop or a timeout
// RESP  | one-cycle upstream ack (err_o also high for unmapped or timed-out accesses)
module bus_multi_dispatch #(
  parameter int NUM_SLAVES     = 8,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_we_i,
  input  logic [15:0]             wb_adr_i,
  input  logic [7:0]              wb_dat_i,
  output logic [7:0]              wb_dat_o,
  output logic                    wb_ack_o,
  output logic [NUM_SLAVES-1:0]   s_wb_stb_o,
  output logic [NUM_SLAVES-1:0]   s_wb_cyc_o,
  output logic                    s_wb_we_o,
  output logic [15:0]             s_wb_adr_o,
  output logic [7:0]              s_wb_dat_o,
  input  logic [8*NUM_SLAVES-1:0] s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]   s_wb_ack_i,
  output logic                    err_o
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
    $error("bus_multi_dispatch: NUM_SLAVES must be 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_multi_dispatch: TIMEOUT_CYCLES must be 1..65535");
  end

  localparam logic [4:0] NUM_SLAVES_5 = 5'(NUM_SLAVES);

  typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic [3:0] sel_in;
  logic       mapped;
  logic       req;
  logic       sel_ack;
  logic [7:0] sel_dat;
  logic       timeout;

  assign sel_in = wb_adr_i[SEL_LSB+3:SEL_LSB];
  assign mapped = {1'b0, sel_in} < NUM_SLAVES_5;
  assign req    = wb_stb_i & wb_cyc_i;

  // Acks and data from slaves other than the registered one are never looked at.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = 8'h00;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx == 4'(k)) begin
        sel_ack = s_wb_ack_i[k];
        sel_dat = s_wb_dat_i[8*k +: 8];
      end
    end
  end

`ifdef BUS_MULTI_DISPATCH_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_16 = 16'(TIMEOUT_CYCLES);
  logic [15:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= 16'd0;
    end else if (state == IDLE && state_nxt == FWD) begin
      to_cnt <= 16'd0;
    end else if (state == FWD && !sel_ack) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  // Fires on the edge where the counter steps up to TIMEOUT_CYCLES.
  assign timeout = (state == FWD) && !sel_ack && (to_cnt + 16'd1 == TIMEOUT_16);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A cyc drop wins over a simultaneous ack or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = mapped ? FWD : RESP;
        end
      end
      FWD: begin
        if (!wb_cyc_i) begin
          state_nxt = IDLE;
        end else if (sel_ack || timeout) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_wb_stb_o = '0;
    s_wb_cyc_o = '0;
    wb_ack_o   = (state == RESP);
    for (int k = 0; k < NUM_SLAVES; k++) begin
      s_wb_stb_o[k] = (state == FWD) && (idx == 4'(k));
      s_wb_cyc_o[k] = (state == FWD) && (idx == 4'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= 4'd0;
      s_wb_adr_o <= 16'h0000;
      s_wb_dat_o <= 8'h00;
      s_wb_we_o  <= 1'b0;
      wb_dat_o   <= 8'h00;
      err_o      <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (state == IDLE && req) begin
        idx        <= sel_in;
        s_wb_adr_o <= wb_adr_i;
        s_wb_dat_o <= wb_dat_i;
        s_wb_we_o  <= wb_we_i;
        if (!mapped) begin
          wb_dat_o <= 8'h00;
          err_o    <= 1'b1;
        end
      end
      if (state == FWD && wb_cyc_i) begin
        if (sel_ack) begin
          if (!s_wb_we_o) begin
            wb_dat_o <= sel_dat;
          end
        end else if (timeout) begin
          wb_dat_o <= 8'hFF;
          err_o    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_multi_dispatch.sv
// Directed bench for bus_multi_dispatch: per-cycle expectations derived from transaction rules,
// checked every cycle, plus literal pins from the worked examples.
module tb_bus_multi_dispatch;
  localparam int NS = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_stb_i, wb_cyc_i, wb_we_i;
  logic [15:0]   wb_adr_i;
  logic [7:0]    wb_dat_i;
  logic [7:0]    wb_dat_o;
  logic          wb_ack_o;
  logic [NS-1:0] s_wb_stb_o, s_wb_cyc_o;
  logic          s_wb_we_o;
  logic [15:0]   s_wb_adr_o;
  logic [7:0]    s_wb_dat_o;
  logic [8*NS-1:0] s_wb_dat_i;
  logic [NS-1:0] s_wb_ack_i;
  logic          err_o;

  always #5 clk = ~clk;

  bus_multi_dispatch #(.NUM_SLAVES(NS), .SEL_LSB(12), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .s_wb_stb_o(s_wb_stb_o), .s_wb_cyc_o(s_wb_cyc_o), .s_wb_we_o(s_wb_we_o),
    .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o), .s_wb_dat_i(s_wb_dat_i),
    .s_wb_ack_i(s_wb_ack_i), .err_o(err_o)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [NS-1:0] e_stb;
  logic          e_ack, e_err, e_we;
  logic [7:0]    e_dat, e_sdat;
  logic [15:0]   e_adr;

  int cyc_n = 0;
  int first_stb_cyc, ack_cyc, ack_count, err_count;
  logic [NS-1:0] first_stb_val;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_n, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_stb", 32'(s_wb_stb_o), 32'(e_stb));
      chk("s_cyc", 32'(s_wb_cyc_o), 32'(e_stb));
      chk("ack", 32'(wb_ack_o), 32'(e_ack));
      chk("err", 32'(err_o), 32'(e_err));
      chk("dat_o", 32'(wb_dat_o), 32'(e_dat));
      chk("s_we", 32'(s_wb_we_o), 32'(e_we));
      chk("s_adr", 32'(s_wb_adr_o), 32'(e_adr));
      chk("s_dat", 32'(s_wb_dat_o), 32'(e_sdat));
      if (s_wb_stb_o != '0 && first_stb_cyc < 0) begin
        first_stb_cyc = cyc_n;
        first_stb_val = s_wb_stb_o;
      end
      if (wb_ack_o) begin
        ack_cyc = cyc_n;
        ack_count++;
      end
      if (err_o) err_count++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    e_stb = '0;
    e_ack = 1'b0;
    e_err = 1'b0;
  endtask

  task automatic obs_clear();
    first_stb_cyc = -1;
    first_stb_val = '0;
    ack_cyc = -1;
    ack_count = 0;
    err_count = 0;
  endtask

  // One upstream transaction. ack_at / abort_at are strobe-cycle indices (0 = first strobe cycle), -1 = never.
  task automatic xact(input logic we, input logic [15:0] adr, input logic [7:0] wdat,
                      input logic [7:0] rdat, input int ack_at, input int abort_at,
                      output int req_cyc);
    int s;
    int i;
    bit fin;
    bit resp;
    s = int'(adr[15:12]);
    obs_clear();
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat;
    idle_exp();
    req_cyc = cyc_n;
    step();
    e_adr = adr; e_we = we; e_sdat = wdat;
    resp = 1'b0;
    if (s >= NS) begin
      e_ack = 1'b1; e_err = 1'b1; e_dat = 8'h00;
      resp = 1'b1;
    end else begin
      fin = 1'b0;
      i = 0;
      while (!fin && i < 2000) begin
        e_stb = NS'(1 << s); e_ack = 1'b0; e_err = 1'b0;
        if (i == ack_at) begin
          s_wb_ack_i = NS'(1 << s);
          s_wb_dat_i = {NS{8'h69}};
          s_wb_dat_i[8*s +: 8] = rdat;
        end else begin
          s_wb_ack_i = ~NS'(1 << s);
          s_wb_dat_i = {NS{8'hC3}};
        end
        if (i == abort_at) begin
          wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        end
        step();
        s_wb_ack_i = '0;
        if (i == abort_at) begin
          idle_exp();
          fin = 1'b1;
        end else if (i == ack_at) begin
          e_stb = '0; e_ack = 1'b1; e_err = 1'b0;
          if (!we) e_dat = rdat;
          fin = 1'b1; resp = 1'b1;
        end
`ifdef BUS_MULTI_DISPATCH_TIMEOUT_EN
        else if (i == TO - 1) begin
          e_stb = '0; e_ack = 1'b1; e_err = 1'b1; e_dat = 8'hFF;
          fin = 1'b1; resp = 1'b1;
        end
`endif
        i++;
      end
      if (!fin) chk("xact_bound", 32'(i), 32'(0));
    end
    if (resp) begin
      step();
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      idle_exp();
    end
    step();
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] expv);
    @(negedge clk);
    chk(name, act, expv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    rst = 1'b1;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 16'h0000; wb_dat_i = 8'h00;
    s_wb_ack_i = '0; s_wb_dat_i = '0;
    idle_exp();
    e_dat = 8'h00; e_sdat = 8'h00; e_adr = 16'h0000; e_we = 1'b0;
    obs_clear();
    step(); step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Read slave 2, immediate ack
    xact(1'b0, 16'h2005, 8'h00, 8'hA5, 0, -1, rc);
    lit("r18_stb_val", 32'(first_stb_val), 32'h04);
    lit("r18_stb_lat", 32'(first_stb_cyc - rc), 32'd1);
    lit("r18_ack_lat", 32'(ack_cyc - rc), 32'd2);
    lit("r18_dat", 32'(wb_dat_o), 32'hA5);

    // Write slave 7, ack after 3 cycles; read data must stay A5
    xact(1'b1, 16'h7010, 8'h3C, 8'h77, 3, -1, rc);
    lit("r19_adr", 32'(s_wb_adr_o), 32'h7010);
    lit("r19_we", 32'(s_wb_we_o), 32'd1);
    lit("r19_sdat", 32'(s_wb_dat_o), 32'h3C);
    lit("r19_ack_cnt", 32'(ack_count), 32'd1);
    lit("r19_ack_lat", 32'(ack_cyc - rc), 32'd5);
    lit("r19_dat_kept", 32'(wb_dat_o), 32'hA5);

    // Unmapped read
    xact(1'b0, 16'hB000, 8'h00, 8'h00, -1, -1, rc);
    lit("r20_no_stb", 32'(first_stb_cyc), 32'hFFFF_FFFF);
    lit("r20_ack_lat", 32'(ack_cyc - rc), 32'd1);
    lit("r20_err_cnt", 32'(err_count), 32'd1);
    lit("r20_dat", 32'(wb_dat_o), 32'h00);

    xact(1'b0, 16'h6ABC, 8'h00, 8'h96, 2, -1, rc);
    lit("rd6_dat", 32'(wb_dat_o), 32'h96);
    xact(1'b1, 16'hF123, 8'h5A, 8'h00, -1, -1, rc);
    lit("unmapped_wr_dat", 32'(wb_dat_o), 32'h00);
    xact(1'b0, 16'h1FFF, 8'h00, 8'h5E, 1, -1, rc);
    lit("rd1_dat", 32'(wb_dat_o), 32'h5E);

    // Slave 1 never acks
    xact(1'b0, 16'h1004, 8'h00, 8'h00, -1, 1000, rc);
`ifdef BUS_MULTI_DISPATCH_TIMEOUT_EN
    lit("r21_ack_lat", 32'(ack_cyc - rc), 32'd5);
    lit("r21_dat", 32'(wb_dat_o), 32'hFF);
    lit("r21_err_cnt", 32'(err_count), 32'd1);
`else
    lit("r21_no_ack", 32'(ack_count), 32'd0);
    lit("r21_no_err", 32'(err_count), 32'd0);
`endif

    // Slave 3: cyc drop together with ack in cycle 2
    xact(1'b0, 16'h3000, 8'h00, 8'hE7, 1, 1, rc);
    lit("r22_no_ack", 32'(ack_count), 32'd0);
    lit("r22_no_err", 32'(err_count), 32'd0);
    xact(1'b0, 16'h4321, 8'h00, 8'h4B, 0, -1, rc);
    lit("r22_next_dat", 32'(wb_dat_o), 32'h4B);
    lit("r22_next_lat", 32'(ack_cyc - rc), 32'd2);

    // Reset during FWD on slave 5
    obs_clear();
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 16'h5555; wb_dat_i = 8'hD2;
    idle_exp();
    step();
    e_adr = 16'h5555; e_we = 1'b1; e_sdat = 8'hD2; e_stb = NS'(1 << 5);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    idle_exp();
    e_dat = 8'h00; e_adr = 16'h0000; e_we = 1'b0; e_sdat = 8'h00;
    step();
    lit("r23_no_ack", 32'(ack_count), 32'd0);
    lit("r23_dat_rst", 32'(wb_dat_o), 32'h00);
    xact(1'b0, 16'h0042, 8'h00, 8'h11, 0, -1, rc);
    lit("r23_next_lat", 32'(ack_cyc - rc), 32'd2);
    lit("r23_next_dat", 32'(wb_dat_o), 32'h11);

    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bus_multi_dispatch.md
BUS_MULTI_DISPATCH -- requirements
Module: bus_multi_dispatch

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: ports clk and rst.
REQ-002 SHALL provide parameters (name, default, meaning):
- NUM_SLAVES, 8, number of downstream wishbone slaves (1..16).
- SEL_LSB, 12, lowest address bit of the 4-bit slave-select field wb_adr_i[SEL_LSB+3:SEL_LSB].
- TIMEOUT_CYCLES, 255, maximum number of cycles to wait for a slave ack (1..65535).
REQ-003 SHALL provide ports (name, direction, width, meaning):
- clk, in, 1, bus clock.
- rst, in, 1, synchronous active-high reset.
- wb_stb_i, wb_cyc_i, wb_we_i, in, 1 each, upstream strobe, cycle and write-enable.
- wb_adr_i, in, 16, upstream address.
- wb_dat_i, in, 8, upstream write data.
- wb_dat_o, out, 8, upstream read data.
- wb_ack_o, out, 1, upstream acknowledge.
- s_wb_stb_o, s_wb_cyc_o, out, NUM_SLAVES each, per-slave strobe and cycle.
- s_wb_we_o, out, 1, shared write-enable.
- s_wb_adr_o, out, 16, shared address.
- s_wb_dat_o, out, 8, shared write data.
- s_wb_dat_i, in, 8*NUM_SLAVES, slave read data; slave k uses bits [8k+7:8k].
- s_wb_ack_i, in, NUM_SLAVES, per-slave acknowledge.
- err_o, out, 1, one-cycle pulse on an unmapped access or a timeout.

Function
REQ-004 SHALL implement states IDLE, FWD and RESP.
REQ-005 In IDLE, when wb_stb_i and wb_cyc_i are both high, SHALL register adr, dat, we and idx = wb_adr_i[SEL_LSB+3:SEL_LSB].
- idx < NUM_SLAVES: go to FWD.
- idx >= NUM_SLAVES: go to RESP with wb_dat_o = 8'h00 and pulse err_o.
REQ-006 In FWD, s_wb_stb_o[idx] and s_wb_cyc_o[idx] SHALL be high and all other bits low; s_wb_adr_o, s_wb_dat_o and s_wb_we_o SHALL hold the registered values.
REQ-007 In FWD, on s_wb_ack_i[idx] high, SHALL capture s_wb_dat_i slice idx into wb_dat_o, drop the slave strobe/cycle on the next edge, and go to RESP.
- Acks from non-selected slaves are ignored.
REQ-008 In RESP, wb_ack_o SHALL be high for exactly one cycle, then the block returns to IDLE.
- The upstream master drops wb_stb_i in the cycle after it sees ack.
REQ-009 Latency: a request sampled in cycle 0 to a slave that acks in the same cycle as its strobe SHALL produce the slave strobe in cycle 1 and wb_ack_o in cycle 2.
- A slave ack in cycle k gives wb_ack_o in cycle k+1.
REQ-010 If wb_cyc_i drops while in FWD, SHALL deassert all slave strobes/cycles on the next edge, return to IDLE, and produce no wb_ack_o and no err_o.
REQ-011 A slave ack and a cyc drop in the same cycle SHALL be treated as an abort (REQ-010).
REQ-012 wb_dat_o SHALL hold its last value outside RESP.
- Writes leave wb_dat_o unchanged, except for an unmapped write, which sets it to 8'h00.
REQ-013 Timeout counter SHALL be 16 bits wide, cleared on entry to FWD, and incremented each FWD cycle without ack.

Reset
REQ-014 rst high SHALL force state IDLE and clear all internal registers.
REQ-015 rst high SHALL force wb_ack_o=0, wb_dat_o=0, s_wb_stb_o=0, s_wb_cyc_o=0, s_wb_we_o=0, s_wb_adr_o=0, s_wb_dat_o=0, err_o=0 and the timeout counter to 0, on the next edge.
REQ-016 rst asserted mid-transaction SHALL abort it with no ack; the first request after reset release is handled normally.

Configuration
REQ-017 Macro BUS_MULTI_DISPATCH_TIMEOUT_EN:
- Defined: when the counter reaches TIMEOUT_CYCLES in FWD, SHALL drop the slave strobe, go to RESP with wb_dat_o = 8'hFF, and pulse err_o.
- Undefined: the counter is not built and FWD waits indefinitely for ack or cyc drop.

Verification
REQ-018 Read of adr 16'h2005 with slave 2 acking in its first strobe cycle, returning 8'hA5 -> s_wb_stb_o = 8'b00000100 in cycle 1; wb_ack_o in cycle 2; wb_dat_o = 8'hA5.
REQ-019 Write of 8'h3C to adr 16'h7010 -> s_wb_we_o = 1, s_wb_adr_o = 16'h7010, s_wb_dat_o = 8'h3C; slave 7 acks after 3 cycles -> a single wb_ack_o one cycle later.
REQ-020 Read of adr 16'hB000 with NUM_SLAVES = 8 -> no slave strobe; wb_ack_o and err_o in cycle 1; wb_dat_o = 8'h00.
REQ-021 With the macro defined and TIMEOUT_CYCLES = 4, read slave 1 that never acks -> strobe drops after 4 cycles; wb_ack_o with 8'hFF and an err_o pulse. With the macro undefined -> no ack after 1000 cycles.
REQ-022 Slave 3 is strobed; wb_cyc_i drops in cycle 2 together with s_wb_ack_i[3] -> strobes low in cycle 3; no wb_ack_o; next request serviced normally.
REQ-023 rst pulsed during FWD -> all outputs 0 next cycle; no ack; a subsequent read of slave 0 completes in 2 cycles.
